// File: rtl/one_to_two_st_demux.sv
// 1:2 AXI-Stream router: each packet goes to port A or B, chosen from sel on its first beat.
// Each master port has a one-deep output register, and a per-port counter tracks completed packets.
//
// state  | meaning
// IDLE   | between packets; the next beat routes by sel
// IN_PKT | mid-packet; the route is frozen in `route` until the tlast beat
module one_to_two_st_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_A,
  output logic                  m_axis_tvalid_A,
  input  logic                  m_axis_tready_A,
  output logic                  m_axis_tlast_A,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_B,
  output logic                  m_axis_tvalid_B,
  input  logic                  m_axis_tready_B,
  output logic                  m_axis_tlast_B,
  output logic                  route,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_A,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_B
);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   eff_route;
  logic   rdy_a, rdy_b;
  logic   accept;
  logic   load_a, load_b;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = s_axis_tlast ? IDLE : IN_PKT;
  end

  // Ready looks only at the port the current beat is routed to.
  always_comb begin
    eff_route     = (state == IDLE) ? sel : route;
    rdy_a         = !m_axis_tvalid_A || m_axis_tready_A;
    rdy_b         = !m_axis_tvalid_B || m_axis_tready_B;
    s_axis_tready = eff_route ? rdy_b : rdy_a;
    accept        = s_axis_tvalid && s_axis_tready;
    load_a        = accept && !eff_route;
    load_b        = accept && eff_route;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        route <= 1'b0;
    else if (accept && state == IDLE)   route <= sel;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_tvalid_A <= 1'b0;
      m_axis_tdata_A  <= '0;
      m_axis_tlast_A  <= 1'b0;
    end else if (load_a) begin
      m_axis_tvalid_A <= 1'b1;
      m_axis_tdata_A  <= s_axis_tdata;
      m_axis_tlast_A  <= s_axis_tlast;
    end else if (m_axis_tready_A) begin
      m_axis_tvalid_A <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_tvalid_B <= 1'b0;
      m_axis_tdata_B  <= '0;
      m_axis_tlast_B  <= 1'b0;
    end else if (load_b) begin
      m_axis_tvalid_B <= 1'b1;
      m_axis_tdata_B  <= s_axis_tdata;
      m_axis_tlast_B  <= s_axis_tlast;
    end else if (m_axis_tready_B) begin
      m_axis_tvalid_B <= 1'b0;
    end
  end

  // Packets count as complete when their tlast beat is accepted at the slave.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt_A <= '0;
      pkt_cnt_B <= '0;
    end else begin
      if (load_a && s_axis_tlast) pkt_cnt_A <= pkt_cnt_A + CNT_WIDTH'(1);
      if (load_b && s_axis_tlast) pkt_cnt_B <= pkt_cnt_B + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_one_to_two_st_demux.sv
// Randomized bench for one_to_two_st_demux against a packet-level scoreboard model.
module tb_one_to_two_st_demux;

  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          sel = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] tdata_a, tdata_b;
  logic          tvalid_a, tvalid_b;
  logic          tready_a = 1'b0, tready_b = 1'b0;
  logic          tlast_a, tlast_b;
  logic          route;
  logic [CW-1:0] cnt_a, cnt_b;

  one_to_two_st_demux #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .sel(sel),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata_A(tdata_a), .m_axis_tvalid_A(tvalid_a), .m_axis_tready_A(tready_a),
    .m_axis_tlast_A(tlast_a),
    .m_axis_tdata_B(tdata_b), .m_axis_tvalid_B(tvalid_b), .m_axis_tready_B(tready_b),
    .m_axis_tlast_B(tlast_b),
    .route(route), .pkt_cnt_A(cnt_a), .pkt_cnt_B(cnt_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: packet-level routing plus one queue per port of {tlast, tdata}
  // beats that have been accepted but not yet taken by the sink.
  typedef logic [DW:0] beat_t;
  beat_t qa[$];
  beat_t qb[$];
  logic  mid_pkt;
  logic  route_m;
  int    cnt_am, cnt_bm;
  logic  last_acc;

  task automatic model_reset();
    qa.delete();
    qb.delete();
    mid_pkt  = 1'b0;
    route_m  = 1'b0;
    cnt_am   = 0;
    cnt_bm   = 0;
    last_acc = 1'b0;
  endtask

  function automatic logic dest();
    return mid_pkt ? route_m : sel;
  endfunction

  function automatic logic exp_ready();
    if (dest()) return (qb.size() == 0) || tready_b;
    else        return (qa.size() == 0) || tready_a;
  endfunction

  task automatic compare_outputs();
    chk("s_tready", 64'(s_tready), 64'(exp_ready()));
    chk("tvalid_A", 64'(tvalid_a), 64'(qa.size() != 0));
    chk("tvalid_B", 64'(tvalid_b), 64'(qb.size() != 0));
    if (qa.size() != 0) chk("beat_A", 64'({tlast_a, tdata_a}), 64'(qa[0]));
    if (qb.size() != 0) chk("beat_B", 64'({tlast_b, tdata_b}), 64'(qb[0]));
    chk("route", 64'(route), 64'(route_m));
    chk("pkt_cnt_A", 64'(cnt_a), 64'(cnt_am));
    chk("pkt_cnt_B", 64'(cnt_b), 64'(cnt_bm));
  endtask

  // Advance the model by what the coming rising edge does.
  task automatic model_step();
    logic d, acc;
    d   = dest();
    acc = s_tvalid && exp_ready();
    if (qa.size() != 0 && tready_a) void'(qa.pop_front());
    if (qb.size() != 0 && tready_b) void'(qb.pop_front());
    if (acc) begin
      if (!mid_pkt) route_m = sel;
      if (d) qb.push_back({s_tlast, s_tdata});
      else   qa.push_back({s_tlast, s_tdata});
      if (s_tlast) begin
        if (d) cnt_bm = (cnt_bm + 1) % (1 << CW);
        else   cnt_am = (cnt_am + 1) % (1 << CW);
      end
      mid_pkt = !s_tlast;
    end
    last_acc = acc;
  endtask

  // Per-phase knobs: valid%, tlast%, A ready%, B ready%, sel=1%, toggle sel each cycle.
  int p_valid [5] = '{100,  90,  95, 60, 80};
  int p_last  [5] = '{ 25, 100,  30, 40, 20};
  int p_ra    [5] = '{100,  70, 100, 50, 90};
  int p_rb    [5] = '{100,  70,   0, 50, 90};
  int p_sel1  [5] = '{ 50,  50,  10, 50, 50};
  bit toggle  [5] = '{  0,   1,   0,  0,  1};
  logic [DW-1:0] seq = 32'h10;

  task automatic drive(input int ph);
    logic hold;
    hold = s_tvalid && !last_acc;
    tready_a = ($urandom_range(99) < p_ra[ph]);
    tready_b = ($urandom_range(99) < p_rb[ph]);
    if (!(hold && !mid_pkt)) begin
      if (toggle[ph]) sel = ~sel;
      else            sel = ($urandom_range(99) < p_sel1[ph]);
    end
    if (!hold) begin
      s_tvalid = ($urandom_range(99) < p_valid[ph]);
      if (s_tvalid) begin
        s_tdata = seq;
        seq     = seq + 1;
        s_tlast = ($urandom_range(99) < p_last[ph]);
      end
    end
  endtask

  task automatic check_reset_values();
    chk("rst_tvalid_A", 64'(tvalid_a), 64'(0));
    chk("rst_tdata_A",  64'(tdata_a),  64'(0));
    chk("rst_tlast_A",  64'(tlast_a),  64'(0));
    chk("rst_tvalid_B", 64'(tvalid_b), 64'(0));
    chk("rst_tdata_B",  64'(tdata_b),  64'(0));
    chk("rst_tlast_B",  64'(tlast_b),  64'(0));
    chk("rst_route",    64'(route),    64'(0));
    chk("rst_cnt_A",    64'(cnt_a),    64'(0));
    chk("rst_cnt_B",    64'(cnt_b),    64'(0));
  endtask

  initial begin
    bit forced_done;
    bit do_rst;
    forced_done = 1'b0;
    model_reset();
    #3;
    check_reset_values();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    #3 resetn = 1'b1;
    for (int ph = 0; ph < 5; ph++) begin
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(posedge clk);
        #1 drive(ph);
        do_rst = ($urandom_range(199) == 0);
        if (!forced_done && cyc > 100 && mid_pkt && !route_m && qa.size() != 0) begin
          do_rst      = 1'b1;
          forced_done = 1'b1;
        end
        if (do_rst) begin
          #2 resetn = 1'b0;
          #1 check_reset_values();
          model_reset();
          @(negedge clk);
          compare_outputs();
          @(posedge clk);
          #1 drive(ph);
          #2 resetn = 1'b1;
        end
        @(negedge clk);
        compare_outputs();
        model_step();
      end
    end
    if (!forced_done) chk("mid_pkt_reset_reached", 64'(forced_done), 64'(1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
